// File: rtl/fpalu_sequencer_if.sv
// Issue/ALU bus between an FP-op requester, the external FP ALU and fpalu_sequencer.
// The slave modport is the sequencer's view; master is everything around it.
interface fpalu_sequencer_if;
  logic        istart;
  logic [3:0]  icontrol;
  logic [31:0] idataa, idatab;
  logic [2:0]  iccidx;
  logic [31:0] ialu_result;
  logic        ialu_nan, ialu_zero, ialu_overflow, ialu_underflow, ialu_comp;
  logic [31:0] oalu_dataa, oalu_datab;
  logic [3:0]  oalu_control;
  logic        obusy, odone;
  logic [31:0] oresult;
  logic        onan, ozero, ooverflow, ounderflow;
  logic        oflag_we, oflag;
  logic [2:0]  oflag_idx;

  modport slave (
    input  istart, icontrol, idataa, idatab, iccidx,
           ialu_result, ialu_nan, ialu_zero, ialu_overflow, ialu_underflow, ialu_comp,
    output oalu_dataa, oalu_datab, oalu_control, obusy, odone, oresult,
           onan, ozero, ooverflow, ounderflow, oflag_we, oflag, oflag_idx
  );

  modport master (
    output istart, icontrol, idataa, idatab, iccidx,
           ialu_result, ialu_nan, ialu_zero, ialu_overflow, ialu_underflow, ialu_comp,
    input  oalu_dataa, oalu_datab, oalu_control, obusy, odone, oresult,
           onan, ozero, ooverflow, ounderflow, oflag_we, oflag, oflag_idx
  );
endinterface

// File: rtl/fpalu_sequencer.sv
// Issues one FP ALU operation, waits its fixed per-opcode latency, then captures
// the result/flags and pulses done (plus a flag-bank write for compares).
module fpalu_sequencer (
  input  logic              iclock,
  input  logic              ireset,
  fpalu_sequencer_if.slave  bus
);
  localparam logic [3:0] OP_ADDS  = 4'd0;
  localparam logic [3:0] OP_SUBS  = 4'd1;
  localparam logic [3:0] OP_MULS  = 4'd2;
  localparam logic [3:0] OP_DIVS  = 4'd3;
  localparam logic [3:0] OP_SQRT  = 4'd4;
  localparam logic [3:0] OP_ABS   = 4'd5;
  localparam logic [3:0] OP_NEG   = 4'd6;
  localparam logic [3:0] OP_CVTSW = 4'd7;
  localparam logic [3:0] OP_CVTWS = 4'd8;
  localparam logic [3:0] OP_CEQ   = 4'd9;
  localparam logic [3:0] OP_CLT   = 4'd10;
  localparam logic [3:0] OP_CLE   = 4'd11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  logic [4:0] cnt;
  logic [2:0] idx_q;

  function automatic logic [4:0] lat_of(input logic [3:0] op);
    case (op)
      OP_ADDS, OP_SUBS:   lat_of = 5'd7;
      OP_MULS:            lat_of = 5'd5;
      OP_DIVS:            lat_of = 5'd6;
      OP_SQRT:            lat_of = 5'd16;
      OP_CVTSW, OP_CVTWS: lat_of = 5'd6;
      default:            lat_of = 5'd1;
    endcase
  endfunction

  always_ff @(posedge iclock) begin
    if (ireset) begin
      state            <= IDLE;
      cnt              <= '0;
      idx_q            <= '0;
      bus.oalu_dataa   <= '0;
      bus.oalu_datab   <= '0;
      bus.oalu_control <= '0;
      bus.obusy        <= 1'b0;
      bus.odone        <= 1'b0;
      bus.oresult      <= '0;
      bus.onan         <= 1'b0;
      bus.ozero        <= 1'b0;
      bus.ooverflow    <= 1'b0;
      bus.ounderflow   <= 1'b0;
      bus.oflag_we     <= 1'b0;
      bus.oflag        <= 1'b0;
      bus.oflag_idx    <= '0;
    end else begin
      bus.odone    <= 1'b0;
      bus.oflag_we <= 1'b0;
      case (state)
        IDLE: if (bus.istart) begin
          bus.oalu_dataa   <= bus.idataa;
          bus.oalu_datab   <= bus.idatab;
          bus.oalu_control <= bus.icontrol;
          idx_q            <= bus.iccidx;
          // Loaded with L-1 so the capture lands on edge A+L with the count at 0.
          cnt              <= lat_of(bus.icontrol) - 5'd1;
          bus.obusy        <= 1'b1;
          state            <= EXEC;
        end
        EXEC: if (cnt == 5'd0) begin
          bus.odone <= 1'b1;
          state     <= DONE;
          case (bus.oalu_control)
            OP_ADDS, OP_SUBS, OP_MULS, OP_DIVS, OP_SQRT, OP_ABS, OP_CVTWS: begin
              bus.oresult    <= bus.ialu_result;
              bus.onan       <= bus.ialu_nan;
              bus.ozero      <= bus.ialu_zero;
              bus.ooverflow  <= bus.ialu_overflow;
              bus.ounderflow <= bus.ialu_underflow;
            end
            OP_NEG, OP_CVTSW: begin
              // Only zero-ness is meaningful here; sign of zero is ignored.
              bus.oresult    <= bus.ialu_result;
              bus.onan       <= 1'b0;
              bus.ozero      <= (bus.ialu_result[30:0] == 31'd0);
              bus.ooverflow  <= 1'b0;
              bus.ounderflow <= 1'b0;
            end
            OP_CEQ, OP_CLT, OP_CLE: begin
              bus.oresult    <= '0;
              bus.onan       <= 1'b0;
              bus.ozero      <= 1'b0;
              bus.ooverflow  <= 1'b0;
              bus.ounderflow <= 1'b0;
              bus.oflag_we   <= 1'b1;
              bus.oflag      <= bus.ialu_comp;
              bus.oflag_idx  <= idx_q;
            end
            default: begin
              bus.oresult    <= '0;
              bus.onan       <= 1'b0;
              bus.ozero      <= 1'b0;
              bus.ooverflow  <= 1'b0;
              bus.ounderflow <= 1'b0;
            end
          endcase
        end else begin
          cnt <= cnt - 5'd1;
        end
        DONE: begin
          bus.obusy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpalu_sequencer.sv
// Randomized scoreboard bench for fpalu_sequencer: stimulus predicts acceptance and
// capture cycle, a negedge monitor pops and checks against a cycle-indexed ALU log.
module tb_fpalu_sequencer;
  localparam logic [3:0] ADDS = 4'd0, SUBS = 4'd1, MULS = 4'd2, DIVS = 4'd3, SQRT = 4'd4,
                         ABS_ = 4'd5, NEG = 4'd6, CVTSW = 4'd7, CVTWS = 4'd8,
                         CEQ = 4'd9, CLT = 4'd10, CLE = 4'd11;
  localparam int MAXC = 8192;

  logic iclock = 1'b0;
  logic ireset = 1'b1;
  fpalu_sequencer_if bus ();
  fpalu_sequencer dut (.iclock(iclock), .ireset(ireset), .bus(bus));

  always #5 iclock = ~iclock;

  typedef struct {
    int         cap;
    logic [3:0] op;
    logic [2:0] idx;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int busy_end = -1, next_free = 0, rst_chk_cyc = 1;
  logic [31:0] ea = 0, eb = 0, lr = 0;
  logic [3:0]  eop = 0;
  logic        lnan = 0, lzero = 0, lov = 0, lun = 0;
  logic [31:0] log_res [MAXC];
  logic [4:0]  log_fl  [MAXC];   // {nan, zero, ovf, unf, comp}
  logic        alu_fix = 1'b0;
  logic [31:0] fix_res = 0;
  logic [4:0]  fix_fl = 0;

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      ADDS, SUBS:   return 7;
      MULS:         return 5;
      DIVS:         return 6;
      SQRT:         return 16;
      CVTSW, CVTWS: return 6;
      default:      return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(posedge iclock) cyc <= cyc + 1;

  // ALU stand-in: fresh random outputs every cycle, logged by the edge that samples them.
  always @(negedge iclock) begin
    logic [31:0] r;
    logic [4:0]  f;
    if (alu_fix) begin
      r = fix_res; f = fix_fl;
    end else begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: r = 32'h0000_0000;
        1: r = 32'h8000_0000;
        default: ;
      endcase
      f = 5'($urandom);
    end
    bus.ialu_result    = r;
    bus.ialu_nan       = f[4];
    bus.ialu_zero      = f[3];
    bus.ialu_overflow  = f[2];
    bus.ialu_underflow = f[1];
    bus.ialu_comp      = f[0];
    log_res[(cyc + 1) % MAXC] = r;
    log_fl[(cyc + 1) % MAXC]  = f;
  end

  // Monitor
  always @(negedge iclock) begin
    exp_t e;
    logic [31:0] r;
    logic [4:0]  f;
    logic        exp_done;
    if (cyc >= 1) begin
      exp_done = (q.size() > 0) && (q[0].cap == cyc);
      chk("odone", bus.odone, exp_done);
      if (exp_done) begin
        e = q.pop_front();
        r = log_res[cyc % MAXC];
        f = log_fl[cyc % MAXC];
        case (e.op)
          ADDS, SUBS, MULS, DIVS, SQRT, ABS_, CVTWS: begin
            lr = r; {lnan, lzero, lov, lun} = f[4:1];
          end
          NEG, CVTSW: begin
            lr = r; lnan = 0; lov = 0; lun = 0; lzero = (r[30:0] == 0);
          end
          default: begin
            lr = 0; lnan = 0; lzero = 0; lov = 0; lun = 0;
          end
        endcase
        if (e.op == CEQ || e.op == CLT || e.op == CLE) begin
          chk("oflag_we", bus.oflag_we, 1);
          chk("oflag", bus.oflag, f[0]);
          chk("oflag_idx", bus.oflag_idx, e.idx);
        end else begin
          chk("oflag_we", bus.oflag_we, 0);
        end
      end else begin
        chk("oflag_we", bus.oflag_we, 0);
      end
      chk("oresult", bus.oresult, lr);
      chk("flags", {bus.onan, bus.ozero, bus.ooverflow, bus.ounderflow}, {lnan, lzero, lov, lun});
      chk("obusy", bus.obusy, cyc <= busy_end);
      chk("oalu_dataa", bus.oalu_dataa, ea);
      chk("oalu_datab", bus.oalu_datab, eb);
      chk("oalu_control", bus.oalu_control, eop);
      if (cyc == rst_chk_cyc) begin
        chk("rst_oflag", bus.oflag, 0);
        chk("rst_oflag_idx", bus.oflag_idx, 0);
      end
    end
  end

  // Drive one cycle of inputs and predict what the coming edge does.
  task automatic step(input logic st, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] idx, input logic rst);
    int e;
    exp_t x;
    @(negedge iclock);
    #1;
    bus.istart = st; bus.icontrol = op; bus.idataa = a; bus.idatab = b; bus.iccidx = idx;
    ireset = rst;
    e = cyc + 1;
    if (rst) begin
      q.delete();
      busy_end = -1; next_free = e + 1; rst_chk_cyc = e;
      ea = 0; eb = 0; eop = 0; lr = 0; lnan = 0; lzero = 0; lov = 0; lun = 0;
    end else if (st && e >= next_free) begin
      x.cap = e + lat_of(op); x.op = op; x.idx = idx;
      q.push_back(x);
      busy_end = x.cap; next_free = x.cap + 2;
      ea = a; eb = b; eop = op;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), $urandom, $urandom, 3'($urandom), 1'b0);
  endtask

  initial begin
    int k;
    bus.istart = 0; bus.icontrol = 0; bus.idataa = 0; bus.idatab = 0; bus.iccidx = 0;
    for (int i = 0; i < 3; i++) step(1'b1, ADDS, 32'h1, 32'h2, 3'd1, 1'b1);

    alu_fix = 1; fix_res = 32'h4040_0000; fix_fl = 5'b00000;
    step(1'b1, ADDS, 32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b0);
    idle(9);
    fix_res = 32'h1234_5678; fix_fl = 5'b10001;
    step(1'b1, CLT, 32'h3F80_0000, 32'h4000_0000, 3'd3, 1'b0);
    idle(3);
    fix_res = 32'h0000_0000; fix_fl = 5'b10000;
    step(1'b1, NEG, 32'h8000_0000, 32'h0, 3'd0, 1'b0);
    idle(3);
    alu_fix = 0;

    step(1'b1, SQRT, 32'h4080_0000, 32'h0, 3'd0, 1'b0);
    idle(3);
    step(1'b1, MULS, 32'h4000_0000, 32'h4000_0000, 3'd0, 1'b0);
    idle(16);

    step(1'b1, DIVS, 32'h4000_0000, 32'h3F80_0000, 3'd2, 1'b0);
    idle(2);
    step(1'b0, ADDS, 32'h0, 32'h0, 3'd0, 1'b1);
    idle(10);

    step(1'b1, 4'hF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3'd5, 1'b0);
    idle(3);

    for (int i = 0; i < 40; i++)
      step(1'b1, 4'($urandom), $urandom, $urandom, 3'($urandom), 1'b0);

    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 2) == 0), 4'($urandom), $urandom, $urandom, 3'($urandom),
           ($urandom_range(0, 199) == 0));

    k = 0;
    while (q.size() > 0 && k < 100) begin
      idle(1);
      k++;
    end
    n_chk++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d ops still outstanding, required 0", q.size());
    end
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpalu_sequencer.md
FPALU_SEQUENCER -- requirements
Module: fpalu_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; the ports are listed below, clock and reset first.
- iclock  in  1  rising-edge clock, shared with the FP ALU.
- ireset  in  1  synchronous, active-high reset.
- istart  in  1  request to issue one FP operation; sampled in IDLE only.
- icontrol  in  4  FP ALU opcode, taken from the shared FPALUOP constants.
- idataa, idatab  in  32  IEEE-754 single-precision operands.
- iccidx  in  3  destination flag-bank index for compare ops.
- ialu_result  in  32  FP ALU result.
- ialu_nan, ialu_zero, ialu_overflow, ialu_underflow  in  1 each  FP ALU status flags.
- ialu_comp  in  1  FP ALU compare result.
- oalu_dataa, oalu_datab  out  32  registered operands driven to the FP ALU.
- oalu_control  out  4  registered opcode driven to the FP ALU.
- obusy  out  1  operation in progress.
- odone  out  1  one-cycle completion pulse.
- oresult  out  32  captured result.
- onan, ozero, ooverflow, ounderflow  out  1 each  captured status flags.
- oflag_we  out  1  flag-bank write strobe.
- oflag  out  1  flag-bank write data.
- oflag_idx  out  3  flag-bank write index.

Function
REQ-002 SHALL implement the states IDLE, EXEC and DONE.
REQ-003 SHALL, in IDLE with istart=1, register icontrol, idataa, idatab and iccidx onto oalu_*/internal, load the latency counter, and go to EXEC (accept edge = edge A).
REQ-004 SHALL hold oalu_dataa, oalu_datab and oalu_control constant from edge A until the next accepted start.
REQ-005 SHALL use the following latency L per opcode:
- ADDS, SUBS: 7.
- MULS: 5.
- DIVS: 6.
- SQRT: 16.
- CVTSW, CVTWS: 6.
- ABS, NEG, CEQ, CLT, CLE: 1.
- Any other code: 1.
REQ-006 SHALL decrement the counter each cycle in EXEC, capture the ALU outputs at edge A+L, and enter DONE.
REQ-007 SHALL assert odone for exactly the one cycle following edge A+L (DONE), then return to IDLE.
REQ-008 SHALL assert obusy in EXEC and DONE, and deassert it in IDLE.
REQ-009 SHALL ignore istart whenever the state is not IDLE; there is no queueing.
REQ-010 SHALL capture flags by operation class:
- ADDS, SUBS, MULS, DIVS, SQRT, ABS, CVTWS: capture ialu_* flags directly.
- NEG, CVTSW: set nan, overflow and underflow to 0, and set ozero=(result[30:0]==0).
- Compares: clear all four flags and set oresult=0.
- Unknown opcode: force oresult and all flags to 0.
REQ-011 SHALL, for CEQ/CLT/CLE only, pulse oflag_we concurrent with odone, with oflag=captured ialu_comp and oflag_idx=registered iccidx.
REQ-012 SHALL keep oflag_we at 0 for all non-compare ops.
REQ-013 SHALL hold oresult and the four status flags stable from capture until the next capture.
REQ-014 SHALL allow a new istart to be accepted on the first IDLE cycle after DONE, giving back-to-back issue at L+2 cycles per op.
REQ-015 SHALL use a 5-bit latency counter; the counter SHALL NOT wrap, and the transition to DONE fires exactly at count 0.

Reset
REQ-016 SHALL, on ireset=1 at a clock edge, go to IDLE and clear these outputs to 0: obusy, odone, oresult, onan, ozero, ooverflow, ounderflow, oflag_we, oflag, oflag_idx, oalu_dataa, oalu_datab, oalu_control.
REQ-017 SHALL let reset take priority over istart and over any capture due on the same edge.
REQ-018 SHALL, on reset mid-EXEC, abort the operation with no odone and no oflag_we for it.

Verification
REQ-019 ADDS, a=0x3F800000, b=0x40000000 -> odone high exactly in the cycle after edge A+7, oresult=0x40400000, all flags 0, oflag_we=0.
REQ-020 CLT, a=1.0, b=2.0, iccidx=3 -> after edge A+1: odone=1, oflag_we=1, oflag=1, oflag_idx=3, oresult=0.
REQ-021 SQRT issued, istart pulsed again at A+4 with MULS -> the second request is ignored, odone occurs once after A+16, obusy stays high throughout.
REQ-022 DIVS issued, ireset asserted at A+3 -> IDLE next cycle, all outputs 0, no odone and no oflag_we for the aborted op.
REQ-023 NEG, a=0x80000000 -> oresult=0x00000000 (ALU-supplied), ozero=1, onan=0.
REQ-024 Opcode 4'hF -> odone after A+1, oresult=0, all flags 0.
